// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and 5-bit opcode encodings used by
// the fetch stage, instruction ROM and decoder.
package cpu_pkg;

   localparam int INSTR_W = 9;
   localparam int PC_W    = 16;
   localparam int OP_W    = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 5'b00000,
      OP_SUB  = 5'b00001,
      OP_AND  = 5'b00010,
      OP_OR   = 5'b00011,
      OP_XOR  = 5'b00100,
      OP_SHL  = 5'b00101,
      OP_SETI = 5'b00110,
      OP_LD   = 5'b01000,
      OP_ST   = 5'b01001,
      OP_BEQ  = 5'b10000,
      OP_BNE  = 5'b10001,
      OP_JMP  = 5'b10010,
      OP_HALT = 5'b11010
   } opcode_t;

   function automatic logic [OP_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OP_W];
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives pc to the combinational ROM and registers the
// returned instruction into IF/ID, honouring redirect, stall and halt.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'd1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] rom_instr,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               halted,
   output logic [PC_W-1:0]    fetch_count
);

   logic is_halt;
   assign is_halt = (instr_opcode(rom_instr) == OP_HALT);

   // NOTE: every state register uses <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         ifid_instr  <= '0;
         ifid_pc     <= '0;
         ifid_valid  <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else if (redirect) begin
         // Redirect wins over stall and halt but never clears halted.
         pc         <= redirect_pc;
         ifid_instr <= '0;
         ifid_valid <= 1'b0;
      end else if (stall) begin
         pc          <= pc;
      end else if (halted) begin
         ifid_instr <= '0;
         ifid_valid <= 1'b0;
      end else begin
         ifid_instr <= rom_instr;
         ifid_pc    <= pc;
         ifid_valid <= 1'b1;
         if (fetch_count != '1)
            fetch_count <= fetch_count + 1'b1;
         if (is_halt)
            halted <= 1'b1;
         else
            pc <= pc + 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a behavioural ROM:
// seti at address 1, optional halt at halt_addr, add with operand pc[3:0] elsewhere.
module tb_fetch_stage;
   import cpu_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] rom_instr;
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic [INSTR_W-1:0] ifid_instr;
   logic [PC_W-1:0]    ifid_pc;
   logic               ifid_valid;
   logic               halted;
   logic [PC_W-1:0]    fetch_count;

   logic               halt_en;
   logic [PC_W-1:0]    halt_addr;
   int                 checks = 0;
   int                 failures = 0;

   localparam logic [INSTR_W-1:0] SETI_I = 9'h060;
   localparam logic [INSTR_W-1:0] HALT_I = 9'h1A0;

   fetch_stage #(.RESET_PC(16'd1)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .rom_instr(rom_instr),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      rom_instr = {5'b00000, pc[3:0]};
      if (pc == 16'd1)
         rom_instr = SETI_I;
      if (halt_en && pc == halt_addr)
         rom_instr = HALT_I;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic check_if(input string tag, input logic [PC_W-1:0] e_pc,
                           input logic [INSTR_W-1:0] e_instr, input logic [PC_W-1:0] e_ipc,
                           input logic e_valid, input logic [PC_W-1:0] e_cnt);
      check({tag, ".pc"}, 32'(pc), 32'(e_pc));
      check({tag, ".instr"}, 32'(ifid_instr), 32'(e_instr));
      check({tag, ".ifid_pc"}, 32'(ifid_pc), 32'(e_ipc));
      check({tag, ".valid"}, 32'(ifid_valid), 32'(e_valid));
      check({tag, ".count"}, 32'(fetch_count), 32'(e_cnt));
   endtask

   initial begin
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      halt_en = 1'b0; halt_addr = 16'd14;

      // Reset values and first fetch.
      do_reset();
      check_if("rst", 16'd1, 9'h000, 16'd0, 1'b0, 16'd0);
      check("rst.halted", 32'(halted), 32'd0);
      step();
      check_if("fetch1", 16'd2, SETI_I, 16'd1, 1'b1, 16'd1);
      step(3);
      check_if("fetch4", 16'd5, 9'h004, 16'd4, 1'b1, 16'd4);

      // Stall holds everything for three cycles.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_if($sformatf("stall%0d", i), 16'd5, 9'h004, 16'd4, 1'b1, 16'd4);
      end
      stall = 1'b0;
      step();
      check_if("resume", 16'd6, 9'h005, 16'd5, 1'b1, 16'd5);

      // Redirect beats a simultaneous stall.
      redirect = 1'b1; redirect_pc = 16'h0020; stall = 1'b1;
      step();
      check("redir.pc", 32'(pc), 32'h20);
      check("redir.valid", 32'(ifid_valid), 32'd0);
      check("redir.instr", 32'(ifid_instr), 32'd0);
      check("redir.count", 32'(fetch_count), 32'd5);
      redirect = 1'b0; stall = 1'b0;
      step();
      check_if("postredir", 16'h0021, 9'h000, 16'h0020, 1'b1, 16'd6);

      // Halt fetched at pc=14.
      halt_en = 1'b1;
      do_reset();
      step(13);
      check_if("prehalt", 16'd14, 9'h00D, 16'd13, 1'b1, 16'd13);
      step();
      check_if("halt", 16'd14, HALT_I, 16'd14, 1'b1, 16'd14);
      check("halt.halted", 32'(halted), 32'd1);
      for (int i = 0; i < 3; i++) begin
         stall = (i == 1);
         step();
         check("halted.pc", 32'(pc), 32'd14);
         check("halted.valid", 32'(ifid_valid), 32'd0);
         check("halted.count", 32'(fetch_count), 32'd14);
      end
      stall = 1'b0;

      // Redirect while halted moves pc but keeps halted.
      redirect = 1'b1; redirect_pc = 16'h0030;
      step();
      redirect = 1'b0;
      check("hredir.pc", 32'(pc), 32'h30);
      check("hredir.halted", 32'(halted), 32'd1);
      step();
      check("hredir.hold", 32'(pc), 32'h30);
      check("hredir.valid", 32'(ifid_valid), 32'd0);

      // Reset clears halt.
      do_reset();
      check("rst2.pc", 32'(pc), 32'd1);
      check("rst2.halted", 32'(halted), 32'd0);
      check("rst2.count", 32'(fetch_count), 32'd0);

      // Halt opcode seen under stall or redirect does not halt.
      redirect = 1'b1; redirect_pc = 16'd14;
      step();
      redirect = 1'b0; stall = 1'b1;
      step();
      check("hstall.halted", 32'(halted), 32'd0);
      stall = 1'b0; redirect = 1'b1;
      step();
      check("hredir2.halted", 32'(halted), 32'd0);
      check("hredir2.pc", 32'(pc), 32'd14);
      redirect = 1'b0;
      step();
      check("hnorm.halted", 32'(halted), 32'd1);
      check("hnorm.count", 32'(fetch_count), 32'd1);
      halt_en = 1'b0;

      // pc wraps modulo 2^16.
      do_reset();
      redirect = 1'b1; redirect_pc = 16'hFFFF;
      step();
      redirect = 1'b0;
      check("wrap.ffff", 32'(pc), 32'hFFFF);
      step();
      check("wrap.pc0", 32'(pc), 32'h0000);
      check("wrap.ipc0", 32'(ifid_pc), 32'hFFFF);
      step();
      check("wrap.pc1", 32'(pc), 32'h0001);
      check("wrap.ipc1", 32'(ifid_pc), 32'h0000);

      // fetch_count saturation.
      do_reset();
      step(65534);
      check("sat.fffe", 32'(fetch_count), 32'hFFFE);
      step();
      check("sat.ffff", 32'(fetch_count), 32'hFFFF);
      step(2);
      check("sat.hold", 32'(fetch_count), 32'hFFFF);
      check("sat.valid", 32'(ifid_valid), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
